// File: rtl/router_input_buffer.sv
// Router input-port flit FIFO: queues single-flit packets, presents a one-hot
// output-port request for the head flit, pops on a matching grant.
// Optional ROUTER_IB_PKT_COUNT_EN adds pkt_count and a sticky grant_err flag.
module router_input_buffer #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [3:0]        req,
  input  logic [3:0]        grant,
  output logic [DATA_W-1:0] out_data,
  output logic              empty,
  output logic              full,
`ifdef ROUTER_IB_PKT_COUNT_EN
  output logic [CNT_W-1:0]  pkt_count,
`endif
  output logic              grant_err
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [1:0]        head_dest;
  logic              push, pop;

  // Extra wrap bit distinguishes full from empty when the low bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Ready depends only on registered pointers, so grant never reaches in_ready.
  assign in_ready  = !full;
  assign push      = in_valid && in_ready;
  assign out_data  = mem[rd_ptr[AW-1:0]];
  assign head_dest = out_data[DATA_W-1 -: 2];
  assign pop       = |(grant & req);

  always_comb begin
    req = 4'b0000;
    if (!empty) req[head_dest] = 1'b1;
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

`ifdef ROUTER_IB_PKT_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_count <= '0;
      grant_err <= 1'b0;
    end else begin
      if (pop) pkt_count <= pkt_count + CNT_W'(1);
      if (|(grant & ~req)) grant_err <= 1'b1;
    end
  end
`else
  assign grant_err = 1'b0;
`endif

endmodule
